pulse_scheduler: RTL and testbench

Sequencer and arbiter in front of the LFM/PSK generators and the output signal multiplexer. It accepts pulse requests for both waveform types and grants one at a time, round-robin when both are pending. It issues a one-cycle start strobe to the granted generator, steers the multiplexer select, and waits for that generator's stop strobe, with a watchdog timeout. It then enforces a programmable guard gap before the next grant.

---
 rtl/pulse_scheduler.sv | 150 +++++++++++++++
 tb/tb_pulse_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler for the LFM/PSK generators: grants one request at a time,
// strobes the generator, steers the output mux, and enforces a watchdog and a guard gap.
module pulse_scheduler #(
  parameter int GUARD_W   = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 REQ_LFM,
  input  logic                 REQ_PSK,
  input  logic                 DONE_LFM,
  input  logic                 DONE_PSK,
  input  logic [GUARD_W-1:0]   GUARD_CYCLES,
  input  logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES,
  input  logic                 CLR_ERR,
  output logic                 START_LFM,
  output logic                 START_PSK,
  output logic [1:0]           SEL,
  output logic                 OUT_EN,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_GUARD} state_t;

  localparam logic                 CH_LFM = 1'b0;
  localparam logic                 CH_PSK = 1'b1;
  localparam logic [GUARD_W-1:0]   G_ONE  = GUARD_W'(1);
  localparam logic [TIMEOUT_W-1:0] T_ONE  = TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_q, last_d;
  logic [GUARD_W-1:0]   guard_len_q, guard_len_d;
  logic [GUARD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 wd_fire_q, wd_fire_d;

  logic                 start_lfm_q, start_lfm_d;
  logic                 start_psk_q, start_psk_d;
  logic [1:0]           sel_q, sel_d;
  logic                 out_en_q, out_en_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic done_granted;
  logic wd_expire;
  logic guard_last;

  assign done_granted = (grant_q == CH_PSK) ? DONE_PSK : DONE_LFM;
  assign wd_expire    = (timeout_q != '0) && (run_cnt_q == timeout_q - T_ONE);
  assign guard_last   = (guard_len_q == '0) || (guard_cnt_q == guard_len_q - G_ONE);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    guard_len_d = guard_len_q;
    guard_cnt_d = guard_cnt_q;
    timeout_d   = timeout_q;
    run_cnt_d   = run_cnt_q;
    wd_fire_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ_LFM || REQ_PSK) begin
          grant_d     = (REQ_LFM && REQ_PSK) ? ~last_q : REQ_PSK;
          guard_len_d = GUARD_CYCLES;
          timeout_d   = TIMEOUT_CYCLES;
          state_d     = S_START;
        end
      end
      S_START: begin
        run_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (run_cnt_q != '1) begin
          run_cnt_d = run_cnt_q + T_ONE;
        end
        // A stop strobe coinciding with expiry counts as a clean stop.
        if (done_granted || wd_expire) begin
          state_d     = S_GUARD;
          last_d      = grant_q;
          guard_cnt_d = '0;
          wd_fire_d   = ~done_granted;
        end
      end
      S_GUARD: begin
        if (guard_last) begin
          state_d = S_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + G_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of the current state's decode, one cycle behind it.
    start_lfm_d = (state_q == S_START) && (grant_q == CH_LFM);
    start_psk_d = (state_q == S_START) && (grant_q == CH_PSK);
    out_en_d    = (state_q == S_START) || (state_q == S_RUN);
    sel_d       = out_en_d ? ((grant_q == CH_PSK) ? 2'b10 : 2'b01) : 2'b00;
    busy_d      = (state_q != S_IDLE);
    err_d       = wd_fire_q ? 1'b1 : (CLR_ERR ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      grant_q     <= CH_LFM;
      last_q      <= CH_PSK;
      guard_len_q <= '0;
      guard_cnt_q <= '0;
      timeout_q   <= '0;
      run_cnt_q   <= '0;
      wd_fire_q   <= 1'b0;
      start_lfm_q <= 1'b0;
      start_psk_q <= 1'b0;
      sel_q       <= 2'b00;
      out_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      guard_len_q <= guard_len_d;
      guard_cnt_q <= guard_cnt_d;
      timeout_q   <= timeout_d;
      run_cnt_q   <= run_cnt_d;
      wd_fire_q   <= wd_fire_d;
      start_lfm_q <= start_lfm_d;
      start_psk_q <= start_psk_d;
      sel_q       <= sel_d;
      out_en_q    <= out_en_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign START_LFM   = start_lfm_q;
  assign START_PSK   = start_psk_q;
  assign SEL         = sel_q;
  assign OUT_EN      = out_en_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: a vector table plus hand sequences drive requests and stop
// strobes; a negedge monitor checks each mux pulse against a queue of expected pulses.
module tb_pulse_scheduler;

  localparam int GW = 16;
  localparam int TW = 20;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_LFM = 1'b0;
  logic          REQ_PSK = 1'b0;
  logic          DONE_LFM = 1'b0;
  logic          DONE_PSK = 1'b0;
  logic [GW-1:0] GUARD_CYCLES = '0;
  logic [TW-1:0] TIMEOUT_CYCLES = '0;
  logic          CLR_ERR = 1'b0;
  logic          START_LFM, START_PSK, OUT_EN, BUSY, TIMEOUT_ERR;
  logic [1:0]    SEL;

  pulse_scheduler #(.GUARD_W(GW), .TIMEOUT_W(TW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_LFM(REQ_LFM), .REQ_PSK(REQ_PSK),
    .DONE_LFM(DONE_LFM), .DONE_PSK(DONE_PSK), .GUARD_CYCLES(GUARD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CLR_ERR(CLR_ERR), .START_LFM(START_LFM),
    .START_PSK(START_PSK), .SEL(SEL), .OUT_EN(OUT_EN), .BUSY(BUSY),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // ch: 0 LFM / 1 PSK; d: stop strobe d cycles after the start strobe, 0 = never.
  typedef struct {
    bit       ch;
    int       g;
    int       t;
    int       d;
    bit [1:0] sel;
    int       len;
    int       gap;
    bit       err;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pulse_no = 0;
  vec_t exp_q[$];
  bit   abort_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act_v, exp_v, $time);
    end
  endtask

  function automatic vec_t mk(bit ch, int g, int t, int d, bit [1:0] sel, int len, int gap, bit err);
    vec_t v;
    v.ch = ch; v.g = g; v.t = t; v.d = d; v.sel = sel; v.len = len; v.gap = gap; v.err = err;
    return v;
  endfunction

  // Monitor: measures each OUT_EN pulse and the following BUSY tail.
  bit       in_pulse = 1'b0;
  bit       measuring = 1'b0;
  int       cur_len = 0;
  int       gap_cnt = 0;
  int       gap_exp = 0;
  logic [1:0] cur_sel = 2'b00;
  vec_t     e;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (OUT_EN) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          cur_len  = 1;
          cur_sel  = SEL;
          check("start_strobe_matches_sel", 32'({START_PSK, START_LFM}), 32'(SEL));
        end else begin
          cur_len++;
          check("sel_held", 32'(SEL), 32'(cur_sel));
          check("start_single_cycle", 32'({START_PSK, START_LFM}), 32'd0);
        end
      end else begin
        check("no_start_without_out_en", 32'({START_PSK, START_LFM}), 32'd0);
        if (in_pulse) begin
          in_pulse = 1'b0;
          if (abort_pulse) begin
            abort_pulse = 1'b0;
          end else if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            pulse_no++;
            $display("pulse %0d: sel=%0d len=%0d err=%0d (expected sel=%0d len=%0d err=%0d)",
                     pulse_no, cur_sel, cur_len, TIMEOUT_ERR, e.sel, e.len, e.err);
            check("pulse_sel", 32'(cur_sel), 32'(e.sel));
            check("pulse_len", 32'(cur_len), 32'(e.len));
            check("err_at_release", 32'(TIMEOUT_ERR), 32'(e.err));
            measuring = 1'b1;
            gap_cnt   = 0;
            gap_exp   = e.gap;
          end
        end
        if (measuring) begin
          if (BUSY) begin
            gap_cnt++;
          end else begin
            check("guard_gap", 32'(gap_cnt), 32'(gap_exp));
            measuring = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_start(output bit ch, output bit ok);
    ok = 1'b0;
    ch = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (START_LFM || START_PSK) begin
        ch = START_PSK;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_start: no start strobe within 400 cycles, expected one");
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: BUSY still high after 400 cycles, expected low");
    end
  endtask

  // Called during the start-strobe cycle; the stop strobe is sampled d edges later.
  task automatic send_done(input bit ch, input int d);
    if (d > 0) begin
      repeat (d - 1) @(posedge CLK);
      #1;
      if (ch) DONE_PSK = 1'b1; else DONE_LFM = 1'b1;
      @(posedge CLK);
      #1;
      DONE_LFM = 1'b0;
      DONE_PSK = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ch, ok;
    @(posedge CLK);
    #1;
    GUARD_CYCLES   = GW'(v.g);
    TIMEOUT_CYCLES = TW'(v.t);
    if (v.ch) REQ_PSK = 1'b1; else REQ_LFM = 1'b1;
    exp_q.push_back(v);
    wait_start(ch, ok);
    REQ_LFM = 1'b0;
    REQ_PSK = 1'b0;
    if (ok) begin
      check("grant_channel", 32'(ch), 32'(v.ch));
      send_done(v.ch, v.d);
    end
    wait_idle();
    @(negedge CLK);
    check("err_sticky", 32'(TIMEOUT_ERR), 32'(v.err));
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    @(negedge CLK);
    check("err_cleared", 32'(TIMEOUT_ERR), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    bit ch, ok;
    int n;

    vecs[0] = mk(1'b0, 4, 0, 10, 2'b01, 11, 4, 1'b0);  // plain LFM pulse
    vecs[1] = mk(1'b1, 2, 8, 0,  2'b10, 9,  2, 1'b1);  // PSK watchdog
    vecs[2] = mk(1'b0, 0, 0, 1,  2'b01, 2,  1, 1'b0);  // shortest run, zero guard
    vecs[3] = mk(1'b1, 1, 5, 5,  2'b10, 6,  1, 1'b0);  // stop meets expiry
    vecs[4] = mk(1'b0, 3, 5, 4,  2'b01, 5,  3, 1'b0);  // stop just before expiry
    vecs[5] = mk(1'b1, 0, 1, 0,  2'b10, 2,  1, 1'b1);  // minimum timeout
    vecs[6] = mk(1'b0, 5, 3, 7,  2'b01, 4,  5, 1'b1);  // late stop lands in guard

    // Reset state, both requests already held.
    REQ_LFM = 1'b1;
    REQ_PSK = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_start_lfm", 32'(START_LFM), 32'd0);
    check("rst_start_psk", 32'(START_PSK), 32'd0);
    check("rst_sel", 32'(SEL), 32'd0);
    check("rst_out_en", 32'(OUT_EN), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(TIMEOUT_ERR), 32'd0);

    // Both held from reset with zero guard: LFM, PSK, LFM, PSK.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'(i % 2), 0, 0, 3, (i % 2 == 1) ? 2'b10 : 2'b01, 4, 1, 1'b0));
    end
    @(posedge CLK);
    #1 RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start(ch, ok);
      if (i == 3) begin
        REQ_LFM = 1'b0;
        REQ_PSK = 1'b0;
      end
      if (ok) begin
        check("rr_order", 32'(ch), 32'(i % 2));
        send_done(ch, 3);
      end
    end
    wait_idle();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Non-granted stop ignored, then granted stop coinciding with expiry.
    @(posedge CLK);
    #1;
    GUARD_CYCLES   = GW'(1);
    TIMEOUT_CYCLES = TW'(6);
    REQ_LFM        = 1'b1;
    exp_q.push_back(mk(1'b0, 1, 6, 6, 2'b01, 7, 1, 1'b0));
    wait_start(ch, ok);
    REQ_LFM = 1'b0;
    @(posedge CLK); #1 DONE_PSK = 1'b1;
    @(posedge CLK); #1 DONE_PSK = 1'b0;
    @(negedge CLK);
    check("psk_done_ignored_sel", 32'(SEL), 32'd1);
    check("psk_done_ignored_en", 32'(OUT_EN), 32'd1);
    repeat (3) @(posedge CLK);
    #1 DONE_LFM = 1'b1;
    @(posedge CLK);
    #1 DONE_LFM = 1'b0;
    wait_idle();
    @(negedge CLK);
    check("tie_no_err", 32'(TIMEOUT_ERR), 32'd0);

    // CLR_ERR held through a watchdog set: set wins, clear follows.
    @(posedge CLK);
    #1;
    GUARD_CYCLES   = GW'(1);
    TIMEOUT_CYCLES = TW'(3);
    REQ_PSK        = 1'b1;
    CLR_ERR        = 1'b1;
    exp_q.push_back(mk(1'b1, 1, 3, 0, 2'b10, 4, 1, 1'b1));
    wait_start(ch, ok);
    REQ_PSK = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (OUT_EN && n < 50);
    check("out_en_fell", 32'(OUT_EN), 32'd0);
    @(negedge CLK);
    check("clr_after_set", 32'(TIMEOUT_ERR), 32'd0);
    CLR_ERR = 1'b0;
    wait_idle();

    // Guard setting changed mid-run only affects the next pulse.
    @(posedge CLK);
    #1;
    GUARD_CYCLES   = GW'(4);
    TIMEOUT_CYCLES = TW'(0);
    REQ_LFM        = 1'b1;
    exp_q.push_back(mk(1'b0, 4, 0, 6, 2'b01, 7, 4, 1'b0));
    wait_start(ch, ok);
    REQ_LFM      = 1'b0;
    GUARD_CYCLES = GW'(100);
    send_done(1'b0, 6);
    wait_idle();
    run_vec(mk(1'b1, 100, 0, 2, 2'b10, 3, 100, 1'b0));

    // Reset mid-run with LFM held: re-grant two edges after release.
    @(posedge CLK);
    #1;
    GUARD_CYCLES = GW'(2);
    REQ_LFM      = 1'b1;
    wait_start(ch, ok);
    repeat (2) @(posedge CLK);
    #1;
    abort_pulse = 1'b1;
    RESET       = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    check("midrun_rst_start", 32'({START_PSK, START_LFM}), 32'd0);
    check("midrun_rst_sel", 32'(SEL), 32'd0);
    check("midrun_rst_out_en", 32'(OUT_EN), 32'd0);
    check("midrun_rst_busy", 32'(BUSY), 32'd0);
    check("midrun_rst_err", 32'(TIMEOUT_ERR), 32'd0);
    exp_q.push_back(mk(1'b0, 2, 0, 2, 2'b01, 3, 2, 1'b0));
    @(posedge CLK);
    #1 check("regrant_not_early", 32'(START_LFM), 32'd0);
    @(posedge CLK);
    #1 check("regrant_two_edges", 32'(START_LFM), 32'd1);
    REQ_LFM = 1'b0;
    send_done(1'b0, 2);
    wait_idle();

    repeat (4) @(negedge CLK);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete within 50000 cycles");
    $fatal(1, "global timeout");
  end

endmodule
